// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer, the instruction register,
// the datapath and unified memory.
interface multicycle_ctrl_fsm_if;
   logic [4:0] opcode;
   logic       mem_ready;
   logic       stall;
   logic       resume;

   logic       mem_req;
   logic       mem_we;
   logic       ir_write;
   logic       pc_write;
   logic       pc_gen_sel;
   logic       branch;
   logic [1:0] alu_op;
   logic       alu_src;
   logic       reg_write;
   logic       mem_to_reg;
   logic [1:0] rd_sel;
   logic       sys;
   logic       halted;
   logic       fault;
   logic [2:0] state;

   modport master (
      input  opcode, mem_ready, stall, resume,
      output mem_req, mem_we, ir_write, pc_write, pc_gen_sel, branch,
             alu_op, alu_src, reg_write, mem_to_reg, rd_sel,
             sys, halted, fault, state
   );

   modport slave (
      output opcode, mem_ready, stall, resume,
      input  mem_req, mem_we, ir_write, pc_write, pc_gen_sel, branch,
             alu_op, alu_src, reg_write, mem_to_reg, rd_sel,
             sys, halted, fault, state
   );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// req/ready memory handshake, stall, SYSTEM halt/resume and memory-timeout fault.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset, no strobes; moves to FETCH on the next edge
//   FETCH  | instruction read in flight; ir_write when memory answers
//   DECODE | opcode classified and latched; illegal opcode -> FAULT
//   EXEC   | ALU controls per class; branches and NOP-SYSTEM commit here
//   MEM    | load/store access in flight; stores commit PC on completion
//   WB     | register write-back and PC commit
//   HALT   | SYSTEM halt, waiting for resume
//   FAULT  | illegal opcode or memory timeout; sticky until reset
module multicycle_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 15,
   parameter bit SYS_HALT    = 1'b1,
   parameter int WCNT_W      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   multicycle_ctrl_fsm_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_NONE   = 4'd0,
      C_R      = 4'd1,
      C_LOAD   = 4'd2,
      C_STORE  = 4'd3,
      C_BRANCH = 4'd4,
      C_OPIMM  = 4'd5,
      C_JALR   = 4'd6,
      C_JAL    = 4'd7,
      C_AUIPC  = 4'd8,
      C_LUI    = 4'd9,
      C_SYSTEM = 4'd10
   } cls_t;

   localparam logic [WCNT_W-1:0] TMO_CNT  = WCNT_W'(MEM_TIMEOUT);
   localparam logic [WCNT_W-1:0] WAIT_MAX = {WCNT_W{1'b1}};
   localparam bit                TMO_EN   = (MEM_TIMEOUT != 0);

   state_t             st;
   state_t             st_nxt;
   cls_t               cls;
   cls_t               cls_dec;
   logic [WCNT_W-1:0]  wait_cnt;
   logic               mem_phase;
   logic               mem_wait;
   logic               timeout;
   logic               access_entry;

   logic               mem_req;
   logic               mem_we;
   logic               ir_write;
   logic               pc_write;
   logic               pc_gen_sel;
   logic               branch;
   logic [1:0]         alu_op;
   logic               alu_src;
   logic               reg_write;
   logic               mem_to_reg;
   logic [1:0]         rd_sel;
   logic               sys;
   logic               halted;
   logic               fault;

   always_comb begin
      cls_dec = C_NONE;
      case (bus.opcode)
         5'b01100: cls_dec = C_R;
         5'b00000: cls_dec = C_LOAD;
         5'b01000: cls_dec = C_STORE;
         5'b11000: cls_dec = C_BRANCH;
         5'b00100: cls_dec = C_OPIMM;
         5'b11001: cls_dec = C_JALR;
         5'b11011: cls_dec = C_JAL;
         5'b00101: cls_dec = C_AUIPC;
         5'b01101: cls_dec = C_LUI;
         5'b11100: cls_dec = C_SYSTEM;
         default:  cls_dec = C_NONE;
      endcase
   end

   // A memory-ready on the terminal-count cycle still completes the access.
   always_comb begin
      mem_phase    = (st == S_FETCH) || (st == S_MEM);
      mem_wait     = mem_phase && !bus.mem_ready;
      timeout      = TMO_EN && mem_wait && (wait_cnt == TMO_CNT);
      access_entry = ((st_nxt == S_FETCH) || (st_nxt == S_MEM)) && (st_nxt != st);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st       <= S_IDLE;
         cls      <= C_NONE;
         wait_cnt <= '0;
      end else begin
         st <= st_nxt;
         if (st == S_DECODE) begin
            cls <= cls_dec;
         end
         if (access_entry) begin
            wait_cnt <= '0;
         end else if (mem_wait && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
         end
      end
   end

   always_comb begin
      st_nxt = st;
      case (st)
         S_IDLE: st_nxt = S_FETCH;
         S_FETCH: begin
            if (bus.mem_ready) begin
               st_nxt = S_DECODE;
            end else if (timeout) begin
               st_nxt = S_FAULT;
            end
         end
         S_DECODE: st_nxt = (cls_dec == C_NONE) ? S_FAULT : S_EXEC;
         S_EXEC: begin
            if (!bus.stall) begin
               case (cls)
                  C_BRANCH:        st_nxt = S_FETCH;
                  C_LOAD, C_STORE: st_nxt = S_MEM;
                  C_SYSTEM:        st_nxt = SYS_HALT ? S_HALT : S_FETCH;
                  default:         st_nxt = S_WB;
               endcase
            end
         end
         S_MEM: begin
            if (bus.mem_ready) begin
               st_nxt = (cls == C_STORE) ? S_FETCH : S_WB;
            end else if (timeout) begin
               st_nxt = S_FAULT;
            end
         end
         S_WB: begin
            if (!bus.stall) begin
               st_nxt = S_FETCH;
            end
         end
         S_HALT: begin
            if (bus.resume) begin
               st_nxt = S_FETCH;
            end
         end
         S_FAULT: st_nxt = S_FAULT;
         default: st_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_gen_sel = 1'b0;
      branch     = 1'b0;
      alu_op     = 2'b00;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      rd_sel     = 2'b00;
      sys        = 1'b0;
      halted     = 1'b0;
      fault      = 1'b0;

      // ALU controls stay valid through MEM so the address holds during the access.
      if ((st == S_EXEC) || (st == S_MEM)) begin
         case (cls)
            C_R:             begin alu_op = 2'b10; alu_src = 1'b0; end
            C_OPIMM:         begin alu_op = 2'b11; alu_src = 1'b1; end
            C_LOAD, C_STORE: begin alu_op = 2'b00; alu_src = 1'b1; end
            C_BRANCH:        begin alu_op = 2'b01; alu_src = 1'b0; end
            default:         begin alu_op = 2'b00; alu_src = 1'b0; end
         endcase
      end

      case (st)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = bus.mem_ready;
         end
         S_EXEC: begin
            if (cls == C_BRANCH) begin
               branch   = !bus.stall;
               pc_write = !bus.stall;
            end else if ((cls == C_SYSTEM) && !SYS_HALT) begin
               sys      = !bus.stall;
               pc_write = !bus.stall;
            end
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = (cls == C_STORE);
            alu_src  = 1'b1;
            pc_write = (cls == C_STORE) && bus.mem_ready;
         end
         S_WB: begin
            reg_write  = !bus.stall;
            pc_write   = !bus.stall;
            mem_to_reg = (cls == C_LOAD);
            pc_gen_sel = (cls == C_JALR);
            case (cls)
               C_AUIPC:       rd_sel = 2'b01;
               C_JAL, C_JALR: rd_sel = 2'b10;
               C_LUI:         rd_sel = 2'b11;
               default:       rd_sel = 2'b00;
            endcase
         end
         S_HALT: begin
            halted   = 1'b1;
            sys      = 1'b1;
            pc_write = bus.resume;
         end
         S_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

   assign bus.mem_req    = mem_req;
   assign bus.mem_we     = mem_we;
   assign bus.ir_write   = ir_write;
   assign bus.pc_write   = pc_write;
   assign bus.pc_gen_sel = pc_gen_sel;
   assign bus.branch     = branch;
   assign bus.alu_op     = alu_op;
   assign bus.alu_src    = alu_src;
   assign bus.reg_write  = reg_write;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.rd_sel     = rd_sel;
   assign bus.sys        = sys;
   assign bus.halted     = halted;
   assign bus.fault      = fault;
   assign bus.state      = st;

endmodule
